// File: rtl/accel_pkg.sv
// Shared types for the accelerometer shot-capture engine.
package accel_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_TRACK = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/accel_shot_capture_if.sv
// Sample/control/display bundle between the flick filter side and the shot-capture engine.
interface accel_shot_capture_if #(
  parameter int unsigned NUM_AXES = 3,
  parameter int unsigned DATA_W   = 16
);
  import accel_pkg::*;

  logic [NUM_AXES-1:0]        in_valid;
  logic [NUM_AXES*DATA_W-1:0] in_flick;
  logic                       arm;
  logic                       freeze_btn;
  logic                       clear;
  logic [NUM_AXES*DATA_W-1:0] out_disp;
  logic [NUM_AXES*DATA_W-1:0] out_peak;
  logic [NUM_AXES-1:0]        trig_mask;
  logic [StateW-1:0]          state;
  logic                       shot_done;
  logic [7:0]                 shot_count;

  // Driver of samples/controls, consumer of display and status
  modport master (
    output in_valid, in_flick, arm, freeze_btn, clear,
    input  out_disp, out_peak, trig_mask, state, shot_done, shot_count
  );

  // The capture engine itself
  modport slave (
    input  in_valid, in_flick, arm, freeze_btn, clear,
    output out_disp, out_peak, trig_mask, state, shot_done, shot_count
  );

endinterface

// File: rtl/accel_peak_ch.sv
// One axis channel: live sample, frozen snapshot and peak register.
module accel_peak_ch #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] flick_i,
  input  logic              snap_en_i,
  input  logic              peak_clr_i,
  input  logic              peak_load_i,
  input  logic              peak_max_i,
  output logic [DATA_W-1:0] live_o,
  output logic [DATA_W-1:0] snap_o,
  output logic [DATA_W-1:0] peak_o
);

  logic [DATA_W-1:0] live_q, snap_q, peak_q, peak_d;

  // Peak next value: clear wins, then direct load on trigger, then running max
  always_comb begin
    peak_d = peak_q;
    if (peak_clr_i) begin
      peak_d = '0;
    end else if (valid_i && peak_load_i) begin
      peak_d = flick_i;
    end else if (valid_i && peak_max_i && (flick_i > peak_q)) begin
      peak_d = flick_i;
    end
  end

  // Channel registers; snapshot takes the pre-update live value
  always_ff @(posedge clk) begin
    if (rst) begin
      live_q <= '0;
      snap_q <= '0;
      peak_q <= '0;
    end else begin
      if (valid_i) live_q <= flick_i;
      if (snap_en_i) snap_q <= live_q;
      peak_q <= peak_d;
    end
  end

  assign live_o = live_q;
  assign snap_o = snap_q;
  assign peak_o = peak_q;

endmodule

// File: rtl/accel_shot_capture.sv
// N-axis shot-capture engine: arm, trigger on threshold, track per-axis peaks over a
// sample window, then hold. Also provides a button snapshot and a registered display bus.
// Optional feature macro: ACCEL_SHOT_CNT_EN enables the saturating shot counter.
module accel_shot_capture
  import accel_pkg::*;
#(
  parameter int unsigned NUM_AXES = 3,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned THRESH   = 1000,
  parameter int unsigned WINDOW   = 64
) (
  input logic clk,
  input logic rst,
  accel_shot_capture_if.slave bus
);

  localparam int unsigned CntW = $clog2(WINDOW) + 1;
  localparam logic [CntW-1:0]   LastCnt = CntW'(WINDOW - 1);
  localparam logic [DATA_W-1:0] ThreshV = DATA_W'(THRESH);

  state_e                     state_q, state_d;
  logic [CntW-1:0]            win_cnt_q, win_cnt_d;
  logic [NUM_AXES-1:0]        trig_q, trig_d;
  logic                       done_q, done_d;
  logic                       frz_q;
  logic [NUM_AXES*DATA_W-1:0] disp_q;

  logic [NUM_AXES-1:0]        hit;
  logic                       frz_edge;
  logic                       peak_clr, peak_load, peak_max;
  logic [NUM_AXES*DATA_W-1:0] live_all, snap_all, peak_all;

  assign frz_edge = bus.freeze_btn & ~frz_q;

  // Per-axis trigger hits on this cycle
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      hit[i] = bus.in_valid[i] && (bus.in_flick[i*DATA_W +: DATA_W] >= ThreshV);
    end
  end

  // FSM next state and per-channel peak controls; clear overrides everything
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    trig_d    = trig_q;
    done_d    = 1'b0;
    peak_clr  = 1'b0;
    peak_load = 1'b0;
    peak_max  = 1'b0;
    if (bus.clear) begin
      peak_clr  = 1'b1;
      trig_d    = '0;
      win_cnt_d = '0;
      state_d   = bus.arm ? S_ARMED : S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.arm) begin
            state_d   = S_ARMED;
            peak_clr  = 1'b1;
            trig_d    = '0;
            win_cnt_d = '0;
          end
        end
        S_ARMED: begin
          if (!bus.arm) begin
            state_d = S_IDLE;
          end else if (|hit) begin
            state_d   = S_TRACK;
            peak_load = 1'b1;
            trig_d    = hit;
            win_cnt_d = CntW'(1);
          end
        end
        S_TRACK: begin
          // arm is deliberately ignored so a started shot always completes
          peak_max = 1'b1;
          if (|bus.in_valid) begin
            win_cnt_d = win_cnt_q + CntW'(1);
            if (win_cnt_q == LastCnt) begin
              state_d = S_HOLD;
              done_d  = 1'b1;
            end
          end
        end
        S_HOLD: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM state, window counter, trigger mask, done pulse, button edge and display register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      win_cnt_q <= '0;
      trig_q    <= '0;
      done_q    <= 1'b0;
      frz_q     <= 1'b0;
      disp_q    <= '0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      trig_q    <= trig_d;
      done_q    <= done_d;
      frz_q     <= bus.freeze_btn;
      if (bus.freeze_btn)       disp_q <= snap_all;
      else if (state_q == S_HOLD) disp_q <= peak_all;
      else                      disp_q <= live_all;
    end
  end

  for (genvar i = 0; i < NUM_AXES; i++) begin : g_ch
    accel_peak_ch #(
      .DATA_W(DATA_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (bus.in_valid[i]),
      .flick_i    (bus.in_flick[i*DATA_W +: DATA_W]),
      .snap_en_i  (frz_edge),
      .peak_clr_i (peak_clr),
      .peak_load_i(peak_load),
      .peak_max_i (peak_max),
      .live_o     (live_all[i*DATA_W +: DATA_W]),
      .snap_o     (snap_all[i*DATA_W +: DATA_W]),
      .peak_o     (peak_all[i*DATA_W +: DATA_W])
    );
  end

  assign bus.out_disp  = disp_q;
  assign bus.out_peak  = peak_all;
  assign bus.trig_mask = trig_q;
  assign bus.state     = state_q;
  assign bus.shot_done = done_q;

`ifdef ACCEL_SHOT_CNT_EN
  logic [7:0] shot_cnt_q;

  // Saturating shot counter, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      shot_cnt_q <= 8'd0;
    end else if (done_q && (shot_cnt_q != 8'hFF)) begin
      shot_cnt_q <= shot_cnt_q + 8'd1;
    end
  end

  assign bus.shot_count = shot_cnt_q;
`else
  assign bus.shot_count = 8'd0;
`endif

endmodule

// File: tb/tb_accel_shot_capture.sv
// Directed bench for accel_shot_capture (NUM_AXES=3, DATA_W=16, THRESH=1000, WINDOW=64).
module tb_accel_shot_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  accel_shot_capture_if #(.NUM_AXES(3), .DATA_W(16)) bus ();

  accel_shot_capture #(
    .NUM_AXES(3),
    .DATA_W  (16),
    .THRESH  (1000),
    .WINDOW  (64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sample strobe cycle; flick is packed {z, y, x}
  task automatic strobe(input logic [2:0] v, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] z);
    bus.in_valid = v;
    bus.in_flick = {z, y, x};
    tick();
    bus.in_valid = '0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  initial begin
    bus.in_valid   = '0;
    bus.in_flick   = '0;
    bus.arm        = 1'b0;
    bus.freeze_btn = 1'b0;
    bus.clear      = 1'b0;

    // 1. reset and live display latency
    rst = 1'b1;
    tick(); tick(); tick();
    chk("rst_state", 64'(bus.state), 64'd0);
    chk("rst_disp", 64'(bus.out_disp), 64'd0);
    chk("rst_peak", 64'(bus.out_peak), 64'd0);
    chk("rst_mask", 64'(bus.trig_mask), 64'd0);
    chk("rst_done", 64'(bus.shot_done), 64'd0);
    chk("rst_cnt", 64'(bus.shot_count), 64'd0);
    rst = 1'b0;
    strobe(3'b001, 16'd123, 16'd0, 16'd0);
    chk("live_lat1", 64'(bus.out_disp), 64'd0);
    tick();
    chk("live_lat2", 64'(bus.out_disp), 64'd123);

    // 2. arm, trigger on 1200, track to peak 1500, window end
    bus.arm = 1'b1;
    tick();
    chk("armed", 64'(bus.state), 64'd1);
    strobe(3'b001, 16'd500, 16'd0, 16'd0);
    chk("below_thr", 64'(bus.state), 64'd1);
    strobe(3'b001, 16'd1200, 16'd0, 16'd0);
    chk("trig_state", 64'(bus.state), 64'd2);
    chk("trig_mask_x", 64'(bus.trig_mask), 64'd1);
    chk("trig_peak", 64'(bus.out_peak), 64'd1200);
    strobe(3'b001, 16'd900, 16'd0, 16'd0);
    strobe(3'b001, 16'd1500, 16'd0, 16'd0);
    // 4. arm dropped during TRACK must not abort the shot
    bus.arm = 1'b0;
    for (int i = 0; i < 60; i++) strobe(3'b001, 16'd100, 16'd0, 16'd0);
    chk("pre_end_state", 64'(bus.state), 64'd2);
    chk("pre_end_done", 64'(bus.shot_done), 64'd0);
    strobe(3'b001, 16'd100, 16'd0, 16'd0);
    chk("hold_state", 64'(bus.state), 64'd3);
    chk("done_pulse", 64'(bus.shot_done), 64'd1);
    tick();
    chk("done_once", 64'(bus.shot_done), 64'd0);
    chk("hold_disp", 64'(bus.out_disp), 64'd1500);
    chk("hold_peak", 64'(bus.out_peak), 64'd1500);
    strobe(3'b001, 16'd5000, 16'd0, 16'd0);
    chk("hold_frozen", 64'(bus.out_peak), 64'd1500);

    // 5. freeze snapshot of live X = 700 while in HOLD
    strobe(3'b001, 16'd700, 16'd0, 16'd0);
    bus.freeze_btn = 1'b1;
    tick();
    strobe(3'b001, 16'd800, 16'd0, 16'd0);
    chk("frz_800", 64'(bus.out_disp), 64'd700);
    strobe(3'b001, 16'd850, 16'd0, 16'd0);
    chk("frz_850", 64'(bus.out_disp), 64'd700);
    strobe(3'b001, 16'd900, 16'd0, 16'd0);
    chk("frz_900", 64'(bus.out_disp), 64'd700);
    bus.freeze_btn = 1'b0;
    tick();
    chk("frz_release", 64'(bus.out_disp), 64'd1500);

    // 4. clear in HOLD with arm=1 -> ARMED, peaks and mask zeroed
    bus.arm = 1'b1;
    pulse_clear();
    chk("clr_armed", 64'(bus.state), 64'd1);
    chk("clr_peak", 64'(bus.out_peak), 64'd0);
    chk("clr_mask", 64'(bus.trig_mask), 64'd0);

    // 3. simultaneous three-axis trigger: 1000, 999, 2000
    strobe(3'b111, 16'd1000, 16'd999, 16'd2000);
    chk("tri_state", 64'(bus.state), 64'd2);
    chk("tri_mask", 64'(bus.trig_mask), 64'd5);
    chk("tri_peak", 64'(bus.out_peak), 64'h07D0_03E7_03E8);
    for (int i = 0; i < 63; i++) strobe(3'b001, 16'd100, 16'd0, 16'd0);
    chk("tri_hold", 64'(bus.state), 64'd3);

    // 4. clear in HOLD with arm=0 -> IDLE
    bus.arm = 1'b0;
    pulse_clear();
    chk("clr_idle", 64'(bus.state), 64'd0);
    chk("clr_idle_peak", 64'(bus.out_peak), 64'd0);

    // 6. clear coincident with a trigger sample
    bus.arm = 1'b1;
    tick();
    bus.clear = 1'b1;
    strobe(3'b001, 16'd3000, 16'd0, 16'd0);
    bus.clear = 1'b0;
    chk("clr_trig_state", 64'(bus.state), 64'd1);
    chk("clr_trig_peak", 64'(bus.out_peak), 64'd0);
    chk("clr_trig_mask", 64'(bus.trig_mask), 64'd0);

`ifdef ACCEL_SHOT_CNT_EN
    chk("cnt_two", 64'(bus.shot_count), 64'd2);
    for (int s = 0; s < 298; s++) begin
      strobe(3'b001, 16'd2000, 16'd0, 16'd0);
      for (int i = 0; i < 63; i++) strobe(3'b001, 16'd10, 16'd0, 16'd0);
      tick();
      pulse_clear();
      if (s == 252) chk("cnt_255", 64'(bus.shot_count), 64'd255);
    end
    chk("cnt_sat", 64'(bus.shot_count), 64'd255);
`else
    chk("cnt_tied", 64'(bus.shot_count), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
